// File: rtl/noc_intr_rx.sv
// ---------------------------------------------------------------------------
// noc_intr_rx
//
// Tile-side receiver for 2-flit interrupt packets arriving from the IOB over
// the 64-bit NoC. Each header is parsed and filtered on destination, message
// type and length. A matching packet has its single payload flit pushed into
// a small FIFO, which presents decoded interrupts to the core-side logic.
// Packets that do not match are drained and counted as drops.
//
// Handshakes: both interfaces use val/rdy. A transfer happens on a rising
// clk edge where val && rdy. The sender holds val and data stable until the
// transfer. noc_in_rdy depends only on FSM state and the FIFO full flag, and
// has no combinational path from intr_rdy.
//
// Optional build macro: NOC_INTR_RX_STATS_EN. When defined, drop_cnt is a
// saturating counter of dropped packets. When undefined, drop_cnt is 16'd0.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   noc_in_val    incoming flit valid
//   noc_in_rdy    receiver ready
//   noc_in_data   incoming flit (64)
//   intr_val      FIFO head holds a decoded interrupt
//   intr_rdy      consumer accepts the head entry
//   intr_data     raw payload flit of the head entry (64)
//   intr_vec      head payload[5:0]
//   intr_tid      head payload[8:6]
//   intr_type     head payload[17:16]
//   fifo_cnt      FIFO occupancy (5)
//   drop_cnt      dropped-packet count (16)
// ---------------------------------------------------------------------------
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd33
`endif

module noc_intr_rx #(
    parameter int          FIFO_DEPTH    = 4,
    parameter logic [13:0] MY_CHIPID     = 14'd0,
    parameter logic [7:0]  MY_X          = 8'd0,
    parameter logic [7:0]  MY_Y          = 8'd0,
    parameter logic [7:0]  INTR_MSG_TYPE = `MSG_TYPE_INTERRUPT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        noc_in_val,
    output logic        noc_in_rdy,
    input  logic [63:0] noc_in_data,
    output logic        intr_val,
    input  logic        intr_rdy,
    output logic [63:0] intr_data,
    output logic [5:0]  intr_vec,
    output logic [2:0]  intr_tid,
    output logic [1:0]  intr_type,
    output logic [4:0]  fifo_cnt,
    output logic [15:0] drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {HDR = 2'd0, PAY = 2'd1, DRAIN = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [7:0]  remaining, remaining_nxt;

    // Header fields of the flit currently on noc_in_data
    logic [13:0] hdr_chipid;
    logic [7:0]  hdr_x, hdr_y, hdr_len, hdr_type;
    logic        keep;

    logic        flit_acc, hdr_acc, push, pop, fifo_full;

    logic [63:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign hdr_chipid = noc_in_data[63:50];
    assign hdr_x      = noc_in_data[49:42];
    assign hdr_y      = noc_in_data[41:34];
    assign hdr_len    = noc_in_data[29:22];
    assign hdr_type   = noc_in_data[21:14];

    // Only a single-payload interrupt addressed to this tile is kept; any
    // other length (including 0) is treated as malformed and dropped.
    assign keep = (hdr_chipid == MY_CHIPID) && (hdr_x == MY_X) && (hdr_y == MY_Y) &&
                  (hdr_type == INTR_MSG_TYPE) && (hdr_len == 8'd1);

    assign fifo_full = (fifo_cnt == 5'(FIFO_DEPTH));
    assign flit_acc  = noc_in_val && noc_in_rdy;
    assign hdr_acc   = flit_acc && (state == HDR);
    assign push      = flit_acc && (state == PAY);
    assign pop       = intr_rdy && (fifo_cnt != 5'd0);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HDR;
            remaining <= 8'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            HDR: begin
                if (flit_acc && (hdr_len != 8'd0)) begin
                    remaining_nxt = hdr_len;
                    state_nxt     = keep ? PAY : DRAIN;
                end
            end
            PAY: begin
                if (flit_acc) state_nxt = HDR;
            end
            DRAIN: begin
                if (flit_acc) begin
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // rdy is held low while reset is asserted, even though the FSM sits in HDR.
    always_comb begin
        noc_in_rdy = 1'b0;
        if (rst_n) begin
            case (state)
                HDR:     noc_in_rdy = 1'b1;
                PAY:     noc_in_rdy = !fifo_full;
                DRAIN:   noc_in_rdy = 1'b1;
                default: noc_in_rdy = 1'b0;
            endcase
        end
    end

    // ---------------- Decoded-interrupt FIFO ----------------
    // Storage is reset so the head outputs read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 64'd0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= 5'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= noc_in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign intr_val  = (fifo_cnt != 5'd0);
    assign intr_data = mem[rd_ptr];
    assign intr_vec  = intr_data[5:0];
    assign intr_tid  = intr_data[8:6];
    assign intr_type = intr_data[17:16];

    // ---------------- Drop statistics ----------------
`ifdef NOC_INTR_RX_STATS_EN
    logic drop_evt;
    assign drop_evt = hdr_acc && !keep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (drop_evt && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`else
    logic unused_hdr_acc;
    assign unused_hdr_acc = hdr_acc;
    assign drop_cnt       = 16'd0;
`endif

endmodule

// File: tb/tb_noc_intr_rx.sv
module tb_noc_intr_rx;

    localparam logic [7:0] INTR_T  = 8'd33;
    localparam logic [7:0] OTHER_T = 8'd7;
`ifdef NOC_INTR_RX_STATS_EN
    localparam int DROP_EN = 1;
`else
    localparam int DROP_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        noc_in_val = 1'b0;
    logic        noc_in_rdy;
    logic [63:0] noc_in_data = 64'd0;
    logic        intr_val;
    logic        intr_rdy = 1'b0;
    logic [63:0] intr_data;
    logic [5:0]  intr_vec;
    logic [2:0]  intr_tid;
    logic [1:0]  intr_type;
    logic [4:0]  fifo_cnt;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int fails   = 0;
    int last_stalls = 0;
    int val_seen = 0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    noc_intr_rx #(
        .FIFO_DEPTH(4), .MY_CHIPID(14'd0), .MY_X(8'd0), .MY_Y(8'd0),
        .INTR_MSG_TYPE(INTR_T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .noc_in_val(noc_in_val), .noc_in_rdy(noc_in_rdy), .noc_in_data(noc_in_data),
        .intr_val(intr_val), .intr_rdy(intr_rdy), .intr_data(intr_data),
        .intr_vec(intr_vec), .intr_tid(intr_tid), .intr_type(intr_type),
        .fifo_cnt(fifo_cnt), .drop_cnt(drop_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // Counts completed consumer handshakes
    always @(negedge clk) if (rst_n && intr_val && intr_rdy) val_seen = val_seen + 1;

    function automatic logic [63:0] make_hdr(input logic [13:0] c, input logic [7:0] x,
                                             input logic [7:0] y, input logic [7:0] len,
                                             input logic [7:0] t);
        return {c, x, y, 4'd0, len, t, 14'd0};
    endfunction

    function automatic int exp_drop(input int n);
        return (DROP_EN != 0) ? n : 0;
    endfunction

    // ---------------- drivers ----------------
    // Presents one flit from a negedge and returns #1 after the accepting edge.
    task automatic send_flit(input logic [63:0] d);
        bit ok = 0;
        @(negedge clk);
        noc_in_val  = 1'b1;
        noc_in_data = d;
        last_stalls = 0;
        for (int i = 0; i < 200; i++) begin
            if (noc_in_rdy) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
            last_stalls++;
            @(negedge clk);
        end
        noc_in_val = 1'b0;
        if (!ok) begin
            vectors++; fails++;
            $display("FAIL send_timeout: flit %h not accepted within 200 cycles", d);
        end
    endtask

    // Holds intr_rdy high and captures n delivered entries into got_q.
    task automatic collect(input int n);
        got_q.delete();
        intr_rdy = 1'b1;
        for (int i = 0; i < 200 && got_q.size() < n; i++) begin
            @(negedge clk);
            if (intr_val) got_q.push_back(intr_data);
        end
        @(posedge clk);
        #1;
        intr_rdy = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++; if (noc_in_rdy !== 1'b0) begin fails++; $display("FAIL rst_rdy: got %b want 0", noc_in_rdy); end
        vectors++; if (intr_val !== 1'b0) begin fails++; $display("FAIL rst_val: got %b want 0", intr_val); end
        vectors++; if (fifo_cnt !== 5'd0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", fifo_cnt); end
        vectors++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        vectors++; if (intr_data !== 64'd0) begin fails++; $display("FAIL rst_data: got %h want 0", intr_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [63:0] p = 64'h0000_0001_0003_0145;
        intr_rdy = 1'b1;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        send_flit(p);
        @(negedge clk);
        vectors++; if (intr_val !== 1'b1) begin fails++; $display("FAIL single_val: got %b want 1", intr_val); end
        vectors++; if (intr_vec !== 6'h05) begin fails++; $display("FAIL single_vec: got %h want 05", intr_vec); end
        vectors++; if (intr_tid !== 3'd5) begin fails++; $display("FAIL single_tid: got %0d want 5", intr_tid); end
        vectors++; if (intr_type !== 2'd3) begin fails++; $display("FAIL single_type: got %0d want 3", intr_type); end
        vectors++; if (intr_data !== p) begin fails++; $display("FAIL single_data: got %h want %h", intr_data, p); end
        @(negedge clk);
        vectors++; if (intr_val !== 1'b0) begin fails++; $display("FAIL single_pulse: got %b want 0", intr_val); end
        vectors++; if (fifo_cnt !== 5'd0) begin fails++; $display("FAIL single_cnt: got %0d want 0", fifo_cnt); end
        intr_rdy = 1'b0;
    endtask

    task automatic test_backpressure;
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(64'hB000_0000_0000_0040 + 64'(i));
        intr_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
            send_flit(exp_q[i]);
        end
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        @(negedge clk);
        vectors++; if (fifo_cnt !== 5'd4) begin fails++; $display("FAIL bp_full_cnt: got %0d want 4", fifo_cnt); end
        vectors++; if (noc_in_rdy !== 1'b0) begin fails++; $display("FAIL bp_full_rdy: got %b want 0", noc_in_rdy); end
        @(posedge clk); #1;
        fork
            send_flit(exp_q[4]);
            collect(5);
        join
        vectors++; if (last_stalls !== 1) begin fails++; $display("FAIL bp_stalls: got %0d want 1", last_stalls); end
        vectors++; if (got_q.size() !== 5) begin fails++; $display("FAIL bp_count: got %0d want 5", got_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                vectors++;
                if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
            end
        end
        vectors++; if (fifo_cnt !== 5'd0) begin fails++; $display("FAIL bp_empty: got %0d want 0", fifo_cnt); end
    endtask

    task automatic test_filter;
        int base = val_seen;
        int stalls = 0;
        intr_rdy = 1'b1;
        send_flit(make_hdr(14'd0, 8'd1, 8'd0, 8'd1, INTR_T));   stalls += last_stalls;
        send_flit(64'hDEAD_0000_0000_0001);                      stalls += last_stalls;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd3, OTHER_T));  stalls += last_stalls;
        for (int i = 0; i < 3; i++) begin
            send_flit(64'hDEAD_0000_0000_0010 + 64'(i));         stalls += last_stalls;
        end
        repeat (3) @(posedge clk); #1;
        vectors++; if (stalls !== 0) begin fails++; $display("FAIL filt_stalls: got %0d want 0", stalls); end
        vectors++; if (val_seen - base !== 0) begin fails++; $display("FAIL filt_val: got %0d deliveries want 0", val_seen - base); end
        vectors++; if (drop_cnt !== 16'(exp_drop(2))) begin fails++; $display("FAIL filt_drop: got %0d want %0d", drop_cnt, exp_drop(2)); end
        intr_rdy = 1'b0;
    endtask

    task automatic test_malformed;
        int base = val_seen;
        int stalls = 0;
        logic [63:0] pg = 64'h0000_0000_0001_0087;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd2, INTR_T));   stalls += last_stalls;
        send_flit(64'hBAD0_0000_0000_0001);                      stalls += last_stalls;
        send_flit(64'hBAD0_0000_0000_0002);                      stalls += last_stalls;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd0, INTR_T));   stalls += last_stalls;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));   stalls += last_stalls;
        send_flit(pg);                                           stalls += last_stalls;
        collect(1);
        vectors++; if (stalls !== 0) begin fails++; $display("FAIL mal_stalls: got %0d want 0", stalls); end
        vectors++; if (got_q.size() !== 1) begin fails++; $display("FAIL mal_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++; if (got_q[0] !== pg) begin fails++; $display("FAIL mal_data: got %h want %h", got_q[0], pg); end
        end
        vectors++; if (val_seen - base !== 1) begin fails++; $display("FAIL mal_val: got %0d deliveries want 1", val_seen - base); end
        vectors++; if (drop_cnt !== 16'(exp_drop(4))) begin fails++; $display("FAIL mal_drop: got %0d want %0d", drop_cnt, exp_drop(4)); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] pn = 64'h0000_0000_0002_00C9;
        intr_rdy = 1'b0;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        send_flit(64'h5555_0000_0000_0001);
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (fifo_cnt !== 5'd0) begin fails++; $display("FAIL rmid_cnt: got %0d want 0", fifo_cnt); end
        vectors++; if (intr_val !== 1'b0) begin fails++; $display("FAIL rmid_val: got %b want 0", intr_val); end
        vectors++; if (noc_in_rdy !== 1'b0) begin fails++; $display("FAIL rmid_rdy: got %b want 0", noc_in_rdy); end
        vectors++; if (intr_data !== 64'd0) begin fails++; $display("FAIL rmid_data: got %h want 0", intr_data); end
        vectors++; if (drop_cnt !== 16'd0) begin fails++; $display("FAIL rmid_drop: got %0d want 0", drop_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        send_flit(pn);
        collect(1);
        vectors++; if (got_q.size() !== 1) begin fails++; $display("FAIL rmid_count: got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            vectors++; if (got_q[0] !== pn) begin fails++; $display("FAIL rmid_new: got %h want %h", got_q[0], pn); end
        end
        @(negedge clk);
        vectors++; if (fifo_cnt !== 5'd0) begin fails++; $display("FAIL rmid_stale: got %0d want 0", fifo_cnt); end
    endtask

    task automatic test_push_pop;
        logic [63:0] pa = 64'hA1A1_0000_0000_0001;
        logic [63:0] pb = 64'hB2B2_0000_0000_0002;
        logic [63:0] pc = 64'hC3C3_0000_0000_0003;
        intr_rdy = 1'b0;
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        send_flit(pa);
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        send_flit(pb);
        send_flit(make_hdr(14'd0, 8'd0, 8'd0, 8'd1, INTR_T));
        @(negedge clk);
        vectors++; if (fifo_cnt !== 5'd2) begin fails++; $display("FAIL pp_pre_cnt: got %0d want 2", fifo_cnt); end
        vectors++; if (intr_data !== pa) begin fails++; $display("FAIL pp_pre_head: got %h want %h", intr_data, pa); end
        @(posedge clk); #1;
        intr_rdy = 1'b1;
        send_flit(pc);
        intr_rdy = 1'b0;
        @(negedge clk);
        vectors++; if (fifo_cnt !== 5'd2) begin fails++; $display("FAIL pp_cnt: got %0d want 2", fifo_cnt); end
        vectors++; if (intr_data !== pb) begin fails++; $display("FAIL pp_head: got %h want %h", intr_data, pb); end
        @(posedge clk); #1;
        collect(2);
        vectors++; if (got_q.size() !== 2) begin fails++; $display("FAIL pp_count: got %0d want 2", got_q.size()); end
        if (got_q.size() == 2) begin
            vectors++; if (got_q[0] !== pb) begin fails++; $display("FAIL pp_order0: got %h want %h", got_q[0], pb); end
            vectors++; if (got_q[1] !== pc) begin fails++; $display("FAIL pp_order1: got %h want %h", got_q[1], pc); end
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_backpressure;
        test_filter;
        test_malformed;
        test_reset_mid;
        test_push_pop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
